// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M execution unit: iterative shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator, behind a valid/ready request/response handshake.
module muldiv_seq #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        F_MUL    = 3'd0,
        F_MULH   = 3'd1,
        F_MULHSU = 3'd2,
        F_MULHU  = 3'd3,
        F_DIV    = 3'd4,
        F_DIVU   = 3'd5,
        F_REM    = 3'd6,
        F_REMU   = 3'd7
    } funct3_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    funct3_t             op;
    logic [4:0]          rd_q;
    logic                neg_q;
    logic                neg_r;
    logic                special;
    logic [XLEN-1:0]     spec_val;
    logic [XLEN-1:0]     mcand;
    logic [2*XLEN-1:0]   acc;

    // ---------------- request decode (used only on the accept edge) ----------------
    funct3_t         req_op;
    logic            req_is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] spec_val_c;

    always_comb begin
        req_op     = funct3_t'(req_funct3);
        req_is_div = req_funct3[2];
        a_signed   = (req_op == F_MULH) || (req_op == F_MULHSU) ||
                     (req_op == F_DIV)  || (req_op == F_REM);
        b_signed   = (req_op == F_MULH) || (req_op == F_DIV) || (req_op == F_REM);
        a_neg      = a_signed && req_rs1[XLEN-1];
        b_neg      = b_signed && req_rs2[XLEN-1];
        a_mag      = a_neg ? -req_rs1 : req_rs1;
        b_mag      = b_neg ? -req_rs2 : req_rs2;
        div_zero   = req_is_div && (req_rs2 == '0);
        div_ovf    = ((req_op == F_DIV) || (req_op == F_REM)) &&
                     (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero)
            spec_val_c = req_funct3[1] ? req_rs1 : '1;
        else
            spec_val_c = req_funct3[1] ? '0 : req_rs1;
    end

    // ---------------- one iteration of each algorithm ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic              div_ok;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        // Multiply: low half of acc holds the multiplier, shifted out LSB first;
        // high half accumulates partial products and shifts down into the low half.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        // Divide: high half is the partial remainder, low half shifts dividend out
        // and quotient bits in. The subtraction only needs XLEN bits when it succeeds.
        div_ok   = acc[2*XLEN-1:XLEN-1] >= {1'b0, mcand};
        div_diff = acc[2*XLEN-2:XLEN-1] - mcand;
        div_next = {div_ok ? div_diff : acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], div_ok};
    end

    // ---------------- final sign fix-up and result select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result;

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quot_fix = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        result   = '0;
        if (special) begin
            result = spec_val;
        end else begin
            unique case (op)
                F_MUL:                      result = prod_fix[XLEN-1:0];
                F_MULH, F_MULHSU, F_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
                F_DIV, F_DIVU:              result = quot_fix;
                F_REM, F_REMU:              result = rem_fix;
                default:                    result = '0;
            endcase
        end
    end

    // ---------------- control FSM and datapath registers ----------------
    // NOTE: every register here uses non-blocking assignment so that all state
    // updates see the pre-edge values of acc/cnt/state regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are plain flops, not a memory array, so
            // clearing them in reset costs nothing and keeps outputs deterministic.
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            cnt        <= '0;
            op         <= F_MUL;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            special    <= 1'b0;
            spec_val   <= '0;
            mcand      <= '0;
            acc        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // flush has no meaning here: nothing is in flight yet
                    if (req_valid && req_ready) begin
                        op        <= req_op;
                        rd_q      <= req_rd;
                        neg_q     <= a_neg ^ b_neg;
                        neg_r     <= a_neg;
                        special   <= div_zero || div_ovf;
                        spec_val  <= spec_val_c;
                        mcand     <= b_mag;
                        acc       <= {{XLEN{1'b0}}, a_mag};
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= (FAST_SPECIAL && (div_zero || div_ovf)) ? S_DONE : S_CALC;
                    end
                end

                S_CALC: begin
                    if (flush) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        acc <= op[2] ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1))
                            state <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (flush || (resp_valid && resp_ready)) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end else if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= result;
                        resp_rd    <= rd_q;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
